shift_sequencer: RTL

Multi-cycle shift controller for the cpu32e2 execute stage. It accepts one shift/rotate command, then drives a single one-bit shift stage once per clock for `count` cycles. Between steps it holds the 32-bit operand and the carry in registers. It reports completion with a one-cycle `done` pulse. It is the low-area alternative to the full barrel shifter and uses the same `shifterPkg::shiftOpSel` operation encoding.

---
 rtl/shift_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: one-bit step per clock, count steps.
// Ports: clk, reset, start, shiftOp, count, dataIn, carryIn -> busy, done, result, carryOut.

package shifterPkg;
   typedef enum logic [2:0] {
      SHL = 3'd0,
      SHR = 3'd1,
      SAR = 3'd2,
      ROL = 3'd3,
      ROR = 3'd4,
      RCL = 3'd5,
      RCR = 3'd6
   } shiftOpSel;
endpackage

module shift_sequencer
   import shifterPkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  shiftOpSel        shiftOp,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] dataIn,
   input  logic             carryIn,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carryOut
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   shiftOpSel        r_op;
   logic [WIDTH-1:0] r_data;
   logic             r_carry;
   logic [CNT_W-1:0] r_rem;

   logic             w_accept;
   logic             w_stepEn;
   logic [WIDTH-1:0] w_stepData;
   logic             w_stepCarry;

   // start is only honoured outside SHIFT
   assign w_accept = start && (r_state != SHIFT);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_next = (count == '0) ? DONE : SHIFT;
            end else begin
               w_next = IDLE;
            end
         end
         SHIFT: begin
            if (r_rem == CNT_W'(1)) begin
               w_next = DONE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // One-bit shift stage; illegal encodings leave data/carry untouched
   always_comb begin
      w_stepEn    = 1'b1;
      w_stepData  = r_data;
      w_stepCarry = r_carry;
      case (r_op)
         SHL: begin
            w_stepCarry = r_data[WIDTH-1];
            w_stepData  = {r_data[WIDTH-2:0], 1'b0};
         end
         SHR: begin
            w_stepCarry = r_data[0];
            w_stepData  = {1'b0, r_data[WIDTH-1:1]};
         end
         SAR: begin
            w_stepCarry = r_data[0];
            w_stepData  = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
         end
         ROL: begin
            w_stepCarry = r_data[WIDTH-1];
            w_stepData  = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
         end
         ROR: begin
            w_stepCarry = r_data[0];
            w_stepData  = {r_data[0], r_data[WIDTH-1:1]};
         end
         RCL: begin
            w_stepCarry = r_data[WIDTH-1];
            w_stepData  = {r_data[WIDTH-2:0], r_carry};
         end
         RCR: begin
            w_stepCarry = r_data[0];
            w_stepData  = {r_carry, r_data[WIDTH-1:1]};
         end
         default: w_stepEn = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op    <= SHL;
         r_data  <= '0;
         r_carry <= 1'b0;
         r_rem   <= '0;
      end else if (w_accept) begin
         r_op    <= shiftOp;
         r_data  <= dataIn;
         r_carry <= carryIn;
         r_rem   <= count;
      end else if (r_state == SHIFT) begin
         r_rem <= r_rem - CNT_W'(1);
         if (w_stepEn) begin
            r_data  <= w_stepData;
            r_carry <= w_stepCarry;
         end
      end
   end

   assign result   = r_data;
   assign carryOut = r_carry;
   assign busy     = (r_state == SHIFT);
   assign done     = (r_state == DONE);

endmodule
